// File: rtl/pmu_ahb_initiator.sv
// Single-outstanding AHB initiator that turns local valid/ready register requests
// into AHB single word transfers and returns a one-cycle response strobe.
module pmu_ahb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  hsel_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic                  hwrite_o,
  output logic [1:0]            htrans_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i,
  input  logic [DATA_WIDTH-1:0] hrdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive data-phase wait state.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timeout_q;
  logic [7:0]            wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wait_cnt  <= '0;
      haddr_o   <= '0;
      hwrite_o  <= 1'b0;
      hwdata_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            wr_q      <= req_write_i;
            wdata_q   <= req_wdata_i;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            // Misaligned requests are answered locally without touching the bus.
            if (req_addr_i[1:0] != 2'b00) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              err_q    <= 1'b0;
              haddr_o  <= req_addr_i;
              hwrite_o <= req_write_i;
              state    <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (hready_i) begin
            wait_cnt <= '0;
            if (wr_q) hwdata_o <= wdata_q;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (hready_i) begin
            err_q   <= (hresp_i != 2'b00);
            rdata_q <= (!wr_q && hresp_i == 2'b00) ? hrdata_i : '0;
            state   <= ST_RESP;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus and response outputs decode only from registered state.
  assign req_ready_o   = (state == ST_IDLE);
  assign rsp_valid_o   = (state == ST_RESP);
  assign rsp_err_o     = rsp_valid_o & err_q;
  assign rsp_timeout_o = rsp_valid_o & timeout_q;
  assign rsp_rdata_o   = rsp_valid_o ? rdata_q : '0;
  assign hsel_o        = (state == ST_ADDR);
  assign htrans_o      = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize_o       = 3'b010;
  assign hburst_o      = 3'b000;

endmodule

// File: doc/pmu_ahb_initiator.md
# pmu_ahb_initiator

Single-outstanding AHB initiator that turns local register-access requests into AHB single transfers toward `pmu_ahb` or any AHB slave. It lets on-chip agents read and configure PMU counters without a CPU. Examples of such agents are a safety monitor or a snapshot engine. It sits between a simple valid/ready request port and the AHB slave port of the PMU, and returns read data or error status on a one-cycle response strobe.

## Interface
- `ADDR_WIDTH`, 32, AHB address width
- `DATA_WIDTH`, 32, AHB data width (only 32 supported; `hsize_o` fixed to word)
- `TIMEOUT_CYCLES`, 255, maximum data-phase wait states before abort (1..255)

- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous reset, active-high
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`
- `req_write_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  ADDR_WIDTH  byte address, must be word aligned
- `req_wdata_i`  in  DATA_WIDTH  write data
- `rsp_valid_o`  out  1  one-cycle response strobe
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and errors
- `rsp_err_o`  out  1  transfer failed (slave error, misalignment, timeout)
- `rsp_timeout_o`  out  1  failure cause was timeout
- `hsel_o`  out  1  slave select (point-to-point use)
- `haddr_o`  out  ADDR_WIDTH  AHB address
- `hwrite_o`  out  1  AHB write
- `htrans_o`  out  2  AHB transfer type (IDLE 00, NONSEQ 10)
- `hsize_o`  out  3  constant 3'b010
- `hburst_o`  out  3  constant 3'b000
- `hwdata_o`  out  DATA_WIDTH  AHB write data
- `hready_i`  in  1  slave ready
- `hresp_i`  in  2  slave response; 00 OKAY, anything else is an error
- `hrdata_i`  in  DATA_WIDTH  AHB read data

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch write, addr and wdata.
  - If `addr[1:0]`!=0, go to RESP with err=1 and no bus activity.
  - Otherwise go to ADDR.
- **ADDR**
  - Drive `hsel_o`=1, `htrans_o`=NONSEQ, `haddr_o`/`hwrite_o` from the latch.
  - Hold these until `hready_i`=1, then go to DATA.
- **DATA**
  - Drive `htrans_o`=IDLE, `hsel_o`=0; `hwdata_o` carries the latched wdata for writes.
  - Wait-state counter increments each cycle `hready_i`=0.
  - When `hready_i`=1: capture `hrdata_i` (reads only) and err=(`hresp_i`!=00), then go to RESP.
  - When the counter reaches `TIMEOUT_CYCLES` with `hready_i` still 0: err=1, timeout=1, go to RESP.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle, then IDLE.
  - `rsp_rdata_o` is forced to 0 when err=1 or the transfer was a write.
- Two-cycle ERROR response: the first ERROR cycle (`hready_i`=0) counts as a wait state; completion happens on the second (`hready_i`=1). `htrans_o` is already IDLE, as the protocol requires.
- The wait-state counter is 8 bits and clears on entry to DATA.
- `haddr_o`/`hwrite_o` hold their last value outside ADDR; `hwdata_o` holds its last value outside DATA.
- No response backpressure. The requester must sample on `rsp_valid_o`.

## Timing
- Reset values:
  - state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_timeout_o`=0
  - `rsp_rdata_o`=0, `hsel_o`=0, `htrans_o`=00, `haddr_o`=0, `hwrite_o`=0, `hwdata_o`=0
- All outputs are registered or decoded from the state register only. There is no combinational path from `hready_i` or `hresp_i` to `htrans_o`.
- Latency with no wait states:
  - request handshake at edge N
  - ADDR in cycle N+1
  - DATA in cycle N+2
  - `rsp_valid_o` in cycle N+3
- Each address-phase or data-phase wait state adds one cycle.
- Misaligned request: `rsp_valid_o` at cycle N+1, `htrans_o` stays IDLE throughout.
- Back-to-back: the next request is accepted in the cycle after RESP, so minimum spacing is 4 cycles per transfer.
- Asserting `rst_i` mid-transfer returns to IDLE immediately:
  - `htrans_o`=IDLE, no response emitted, the in-flight transfer is abandoned.
  - The slave-side data phase must be reset by the same reset.

## Test plan
- **Read OK, zero wait:** read 0x80100004 with slave returning 0x0000002A → NONSEQ seen 1 cycle, `rsp_valid_o` at N+3, rdata=0x2A, err=0.
- **Write to PMU:** write 0x801000AC←0xCAFECAFE against `pmu_ahb` → `hwdata_o`=0xCAFECAFE in the data phase; a subsequent read of 0x801000AC returns 0xCAFECAFE.
- **Wait states:** `hready_i` held low 2 cycles in ADDR and 3 in DATA → NONSEQ stable for 3 cycles, `rsp_valid_o` at N+8, single pulse.
- **Slave ERROR:** two-cycle `hresp_i`=01 → `htrans_o`=IDLE both cycles, err=1, rdata=0, timeout=0.
- **Timeout and misalignment:**
  - `TIMEOUT_CYCLES`=4 with `hready_i` stuck low in DATA → err=1, timeout=1 after 4 wait cycles.
  - Address 0x80100002 → err=1 at N+1, no NONSEQ.
- **Reset mid-op:** assert `rst_i` during DATA → all outputs return to reset values asynchronously, no `rsp_valid_o`; the next request completes normally.
